// File: rtl/sync_wedge_mc.sv
// sync_wedge_mc: multi-channel input synchronizer with glitch filter,
// registered level output, rise/fall edge pulses and sticky event flags.
// Each channel: STAGES-flop synchronizer -> optional stability filter
// (FILT_CYCLES, 0 = bypass) -> serial_q level register -> edge pulses ->
// event/overflow flags. Channels are independent; irq_o ORs all events.
// Optional build macro SYNC_WEDGE_MC_OVF_EN enables the sticky overflow
// flags; without it ovf_o is tied low and no overflow flops exist.
module sync_wedge_mc #(
    parameter int NUM_CH      = 4,
    parameter int STAGES      = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_CH-1:0]     en_i,
    input  logic [NUM_CH-1:0]     serial_i,
    input  logic [2*NUM_CH-1:0]   edge_mode_i,
    input  logic [NUM_CH-1:0]     event_clr_i,
    output logic [NUM_CH-1:0]     serial_o,
    output logic [NUM_CH-1:0]     r_edge_o,
    output logic [NUM_CH-1:0]     f_edge_o,
    output logic [NUM_CH-1:0]     event_o,
    output logic [NUM_CH-1:0]     ovf_o,
    output logic                  irq_o
);

    logic [NUM_CH-1:0] sync_w;
    logic [NUM_CH-1:0] flt_w;
    logic [NUM_CH-1:0] match_w;
    logic [NUM_CH-1:0] r_edge_w;
    logic [NUM_CH-1:0] f_edge_w;
    logic [NUM_CH-1:0] serial_q;
    logic [NUM_CH-1:0] serial_d;
    logic [NUM_CH-1:0] event_q;
    logic [NUM_CH-1:0] event_d;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [STAGES-1:0] sync_q;

            // Free-running synchronizer; ignores en_i so the sampled level is always fresh
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[STAGES-2:0], serial_i[c]};
                end
            end

            assign sync_w[c] = sync_q[STAGES-1];

            if (FILT_CYCLES > 0) begin : g_filt
                localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
                localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

                logic [CNT_W-1:0] cnt_q;
                logic [CNT_W-1:0] cnt_d;
                logic             flt_q;
                logic             flt_d;

                // Stability filter: flt follows sync only after FILT_CYCLES consecutive
                // enabled cycles of disagreement; any agreeing cycle restarts the count
                always_comb begin
                    cnt_d = cnt_q;
                    flt_d = flt_q;
                    if (en_i[c]) begin
                        if (sync_w[c] != flt_q) begin
                            if (cnt_q == CNT_LAST) begin
                                flt_d = sync_w[c];
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                end

                // Filter state registers
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        cnt_q <= '0;
                        flt_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        flt_q <= flt_d;
                    end
                end

                assign flt_w[c] = flt_q;
            end else begin : g_bypass
                assign flt_w[c] = sync_w[c];
            end

            assign match_w[c] = (r_edge_w[c] & edge_mode_i[2*c])
                              | (f_edge_w[c] & edge_mode_i[2*c+1]);
        end
    endgenerate

    // Edge pulses compare the new filtered level against the last registered one
    assign r_edge_w = en_i & flt_w & ~serial_q;
    assign f_edge_w = en_i & ~flt_w & serial_q;

    assign serial_d = (serial_q & ~en_i) | (flt_w & en_i);
    // A matching edge sets the event even when a clear arrives in the same cycle
    assign event_d  = match_w | (event_q & ~event_clr_i);

    // Level and event registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            serial_q <= '0;
            event_q  <= '0;
        end else begin
            serial_q <= serial_d;
            event_q  <= event_d;
        end
    end

`ifdef SYNC_WEDGE_MC_OVF_EN
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    // Overflow: a second matching edge while the event is still pending; clear wins
    assign ovf_d = ~event_clr_i & (ovf_q | (match_w & event_q));

    // Overflow register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = '0;
`endif

    assign serial_o = serial_q;
    assign r_edge_o = r_edge_w;
    assign f_edge_o = f_edge_w;
    assign event_o  = event_q;
    assign irq_o    = |event_q;

endmodule

// File: tb/tb_sync_wedge_mc.sv
// tb_sync_wedge_mc: drives two instances (filtered FILT_CYCLES=4 and bypass
// FILT_CYCLES=0) with shared stimulus; a behavioural model predicts outputs,
// which a scoreboard queue hands to a negedge monitor for comparison.
module tb_sync_wedge_mc;

    localparam int NCH = 4;
    localparam int STG = 2;
    localparam int FA  = 4;
`ifdef SYNC_WEDGE_MC_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    typedef struct packed {
        logic [NCH-1:0] ser;
        logic [NCH-1:0] r;
        logic [NCH-1:0] f;
        logic [NCH-1:0] ev;
        logic [NCH-1:0] ov;
        logic           irq;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i;
    logic [NCH-1:0]     en_i, serial_i, event_clr_i;
    logic [2*NCH-1:0]   edge_mode_i;

    logic [NCH-1:0] a_ser, a_r, a_f, a_ev, a_ov;
    logic           a_irq;
    logic [NCH-1:0] b_ser, b_r, b_f, b_ev, b_ov;
    logic           b_irq;

    sync_wedge_mc #(.NUM_CH(NCH), .STAGES(STG), .FILT_CYCLES(FA)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .serial_i(serial_i),
        .edge_mode_i(edge_mode_i), .event_clr_i(event_clr_i),
        .serial_o(a_ser), .r_edge_o(a_r), .f_edge_o(a_f),
        .event_o(a_ev), .ovf_o(a_ov), .irq_o(a_irq)
    );

    sync_wedge_mc #(.NUM_CH(NCH), .STAGES(STG), .FILT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .serial_i(serial_i),
        .edge_mode_i(edge_mode_i), .event_clr_i(event_clr_i),
        .serial_o(b_ser), .r_edge_o(b_r), .f_edge_o(b_f),
        .event_o(b_ev), .ovf_o(b_ov), .irq_o(b_irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit shq[NCH][$];          // recent raw samples, newest first
    bit m_flt[2][NCH];
    int m_run[2][NCH];        // consecutive enabled cycles the level disagreed
    bit m_sq [2][NCH];
    bit m_ev [2][NCH];
    bit m_ov [2][NCH];

    function automatic int filt(int m);
        return (m == 0) ? FA : 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            shq[c].delete();
            for (int s = 0; s < STG; s++) shq[c].push_back(1'b0);
            for (int m = 0; m < 2; m++) begin
                m_flt[m][c] = 0; m_run[m][c] = 0; m_sq[m][c] = 0;
                m_ev[m][c] = 0;  m_ov[m][c] = 0;
            end
        end
    endfunction

    function automatic bit m_sync(int c);
        return shq[c][STG-1];
    endfunction

    function automatic bit m_level(int m, int c);
        return (filt(m) == 0) ? m_sync(c) : m_flt[m][c];
    endfunction

    function automatic obs_t model_obs(int m);
        obs_t o;
        o = '0;
        for (int c = 0; c < NCH; c++) begin
            bit lv;
            lv = m_level(m, c);
            o.ser[c] = m_sq[m][c];
            o.r[c]   = en_i[c] & lv & ~m_sq[m][c];
            o.f[c]   = en_i[c] & ~lv & m_sq[m][c];
            o.ev[c]  = m_ev[m][c];
            o.ov[c]  = m_ov[m][c];
        end
        o.irq = |o.ev;
        return o;
    endfunction

    function automatic void model_step();
        obs_t pre;
        if (rst_i) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            pre = model_obs(m);
            for (int c = 0; c < NCH; c++) begin
                bit match, lv;
                lv = m_level(m, c);
                match = (pre.r[c] & edge_mode_i[2*c]) | (pre.f[c] & edge_mode_i[2*c+1]);
                if (OVF) begin
                    if (event_clr_i[c]) m_ov[m][c] = 0;
                    else if (match && m_ev[m][c]) m_ov[m][c] = 1;
                end
                if (match) m_ev[m][c] = 1;
                else if (event_clr_i[c]) m_ev[m][c] = 0;
                if (en_i[c]) begin
                    m_sq[m][c] = lv;
                    if (filt(m) > 0) begin
                        if (m_sync(c) != m_flt[m][c]) begin
                            m_run[m][c]++;
                            if (m_run[m][c] == filt(m)) begin
                                m_flt[m][c] = m_sync(c);
                                m_run[m][c] = 0;
                            end
                        end else begin
                            m_run[m][c] = 0;
                        end
                    end
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            shq[c].push_front(serial_i[c]);
            void'(shq[c].pop_back());
        end
    endfunction

    // ---------------- scoreboard ----------------
    obs_t qa[$];
    obs_t qb[$];

    logic               s_rst;
    logic [NCH-1:0]     s_en, s_ser, s_clr;
    logic [2*NCH-1:0]   s_mode;

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        rst_i       = s_rst;
        en_i        = s_en;
        serial_i    = s_ser;
        event_clr_i = s_clr;
        edge_mode_i = s_mode;
        qa.push_back(model_obs(0));
        qb.push_back(model_obs(1));
    endtask

    task automatic cmp_obs(input string tag, input obs_t got, input obs_t exp);
        check({tag, "_serial"}, 32'(got.ser), 32'(exp.ser));
        check({tag, "_r_edge"}, 32'(got.r),   32'(exp.r));
        check({tag, "_f_edge"}, 32'(got.f),   32'(exp.f));
        check({tag, "_event"},  32'(got.ev),  32'(exp.ev));
        check({tag, "_ovf"},    32'(got.ov),  32'(exp.ov));
        check({tag, "_irq"},    32'(got.irq), 32'(exp.irq));
    endtask

    // Monitor: compare every presented output set against the queued prediction
    always @(negedge clk) begin
        if (qa.size() > 0 && qb.size() > 0) begin
            obs_t ea, eb;
            ea = qa.pop_front();
            eb = qb.pop_front();
            cmp_obs("filt", {a_ser, a_r, a_f, a_ev, a_ov, a_irq}, ea);
            cmp_obs("byp",  {b_ser, b_r, b_f, b_ev, b_ov, b_irq}, eb);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        s_rst = 1'b1; s_en = '1; s_ser = '0; s_clr = '0;
        s_mode = 8'b11_11_11_01;
        rst_i = 1'b1; en_i = '1; serial_i = '0; event_clr_i = '0; edge_mode_i = s_mode;

        repeat (3) cycle();
        check("reset_serial", 32'(a_ser), 32'h0);
        check("reset_event",  32'(a_ev),  32'h0);
        check("reset_irq",    32'(a_irq), 32'h0);
        s_rst = 1'b0;
        repeat (6) cycle();

        // ch0 rising edge latency through filter
        s_ser[0] = 1'b1;
        cycle();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check($sformatf("lat_r0_k%0d", k), 32'(a_r[0]), 32'(k == STG + FA));
            if (k == STG + FA + 1) begin
                check("lat_event0", 32'(a_ev[0]), 32'h1);
                check("lat_irq",    32'(a_irq),   32'h1);
            end
        end

        // 3-cycle glitch on ch1 must be rejected by the filter
        s_ser[1] = 1'b1;
        repeat (3) cycle();
        s_ser[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check("glitch_r1",   32'(a_r[1]),   32'h0);
            check("glitch_ser1", 32'(a_ser[1]), 32'h0);
        end

        // ch2 rises while disabled, pulse only after enabling
        s_en[2] = 1'b0; s_ser[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("dis_r2", 32'(a_r[2]), 32'h0);
        end
        s_en[2] = 1'b1;
        cycle();
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check($sformatf("en_r2_k%0d", k), 32'(a_r[2]), 32'(k == FA));
        end

        // ch3 two edges then a cleared third edge
        s_ser[3] = 1'b1;
        repeat (10) cycle();
        s_ser[3] = 1'b0;
        repeat (10) cycle();
        check("ovf_event3", 32'(a_ev[3]), 32'h1);
        check("ovf_ovf3",   32'(a_ov[3]), 32'(OVF));
        s_ser[3] = 1'b1;
        cycle();
        for (int k = 1; k <= 7; k++) begin
            s_clr[3] = (k == STG + FA);
            cycle();
        end
        s_clr[3] = 1'b0;
        check("clr_event3", 32'(a_ev[3]), 32'h1);
        check("clr_ovf3",   32'(a_ov[3]), 32'h0);
        repeat (4) cycle();

        // reset in the middle of a ch0 falling-edge filter count
        s_ser[0] = 1'b0;
        repeat (4) cycle();
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        cycle();
        check("rst_mid_a", 32'({a_ser, a_r, a_f, a_ev, a_ov, a_irq}), 32'h0);
        check("rst_mid_b", 32'({b_ser, b_r, b_f, b_ev, b_ov, b_irq}), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("post_rst_r0", 32'(a_r[0]), 32'h0);
            check("post_rst_f0", 32'(a_f[0]), 32'h0);
            check($sformatf("post_rst_r3_k%0d", k), 32'(a_r[3]), 32'(k == STG + FA));
        end

        // bypass instance: ch1 toggling every 4 cycles
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 0) s_ser[1] = ~s_ser[1];
            cycle();
            check($sformatf("byp_r1_k%0d", k), 32'(b_r[1]), 32'((k % 4 == STG) && s_ser[1]));
            check($sformatf("byp_f1_k%0d", k), 32'(b_f[1]), 32'((k % 4 == STG) && !s_ser[1]));
        end

        // randomized traffic, checked by the scoreboard only
        for (int k = 0; k < 800; k++) begin
            s_rst = ($urandom_range(0, 249) == 0);
            for (int c = 0; c < NCH; c++) begin
                s_en[c]  = ($urandom_range(0, 7) != 0);
                s_clr[c] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 11) == 0) s_ser[c] = ~s_ser[c];
            end
            if (k % 50 == 0) s_mode = 8'($urandom);
            cycle();
        end
        s_rst = 1'b0; s_clr = '0;
        repeat (3) cycle();

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(qa.size() + qb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_wedge_mc.md
SYNC_WEDGE_MC -- requirements
Module: sync_wedge_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the channel count (1..32).
REQ-002 SHALL have parameter STAGES, default 2, giving the synchronizer depth per channel (>=2).
REQ-003 SHALL have parameter FILT_CYCLES, default 4, giving the glitch-filter stability length; 0 means bypass (0..255).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en_i, input, NUM_CH bits: per-channel enable.
REQ-007 SHALL have port serial_i, input, NUM_CH bits: asynchronous channel inputs.
REQ-008 SHALL have port edge_mode_i, input, 2*NUM_CH bits: per-channel event mode in bits [2c+1:2c]; 00 none, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port event_clr_i, input, NUM_CH bits: per-channel clear of pending and overflow.
REQ-010 SHALL have port serial_o, output, NUM_CH bits: registered filtered level (serial_q).
REQ-011 SHALL have ports r_edge_o and f_edge_o, output, NUM_CH bits each: single-cycle edge pulses.
REQ-012 SHALL have port event_o, output, NUM_CH bits: sticky pending event flags.
REQ-013 SHALL have port ovf_o, output, NUM_CH bits: sticky overflow flags.
REQ-014 SHALL have port irq_o, output, 1 bit: OR of all event_o bits.

Function
REQ-015 SHALL pass each serial_i bit through a free-running STAGES-flop synchronizer (sync) that runs regardless of en_i.
REQ-016 SHALL, with FILT_CYCLES>0, keep a per-channel filtered level flt and a counter; when en_i[c]=1 and sync!=flt, the counter SHALL increment, and flt SHALL take sync on the cycle the counter reaches FILT_CYCLES-1 with sync still differing, then the counter SHALL clear.
REQ-017 SHALL clear the filter counter in any enabled cycle where sync==flt, so shorter glitches are rejected.
REQ-018 SHALL, with FILT_CYCLES=0, make flt equal sync combinationally and instantiate no counter.
REQ-019 SHALL update serial_q<=flt only when en_i[c]=1; when en_i[c]=0, the filter counter, flt and serial_q SHALL hold.
REQ-020 SHALL drive r_edge_o[c] = en_i[c] & flt & ~serial_q and f_edge_o[c] = en_i[c] & ~flt & serial_q, combinationally, each lasting exactly one enabled cycle.
REQ-021 SHALL have a latency from a stable serial_i change to the edge pulse of STAGES+FILT_CYCLES clock edges (pulse visible in the following cycle).
REQ-022 SHALL set event_o[c] at the next edge when an edge pulse matches edge_mode_i[c]; mode 00 SHALL never set it.
REQ-023 SHALL clear event_o[c] and ovf_o[c] on event_clr_i[c]; if a set and a clear coincide, the set SHALL win for event_o and the clear SHALL win for ovf_o.
REQ-024 SHALL set ovf_o[c] when a matching edge occurs while event_o[c]=1 and event_clr_i[c]=0.
REQ-025 SHALL keep channels fully independent; the only cross-channel logic is irq_o.

Reset
REQ-026 SHALL, when rst_i=1 at a clock edge, reset the synchronizer flops, flt, counters, serial_q, event_o and ovf_o to 0, overriding every other input including mid-filter and mid-event activity.
REQ-027 SHALL, with serial_i held at 1 through reset, report a rising edge after STAGES+FILT_CYCLES edges once reset is released.

Configuration
REQ-028 SHALL implement overflow tracking only when macro SYNC_WEDGE_MC_OVF_EN is defined; otherwise ovf_o SHALL be tied to 0 and no overflow flops SHALL exist.

Verification
REQ-029 SHALL verify: NUM_CH=4, STAGES=2, FILT_CYCLES=4, ch0 mode 01, serial_i[0] 0->1 and held -> r_edge_o[0] high for 1 cycle, 6 edges after the change; event_o[0]=1 and irq_o=1 one cycle later.
REQ-030 SHALL verify: a 3-cycle-wide pulse on serial_i[1] with FILT_CYCLES=4 -> no edge pulse, serial_o[1] stays 0.
REQ-031 SHALL verify: with en_i[2]=0, serial_i[2] rises -> no pulse; en_i[2] set to 1 later -> the pulse occurs after FILT_CYCLES enabled cycles.
REQ-032 SHALL verify: ch3 mode 11, two edges with no clear -> event_o[3]=1 and ovf_o[3]=1 (0 without SYNC_WEDGE_MC_OVF_EN); event_clr_i[3] on the next matching edge -> event_o[3]=1, ovf_o[3]=0.
REQ-033 SHALL verify: rst_i asserted for 1 cycle mid-filter count -> all outputs 0 next cycle; no stale edge pulse after release.
REQ-034 SHALL verify: with FILT_CYCLES=0, serial_i toggling each 4 cycles -> alternating r/f pulses, each STAGES edges after its input change.
